// File: rtl/divider_controller_pkg.sv
// Purpose: shared FSM state encoding and default widths for the divider controller slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package divider_controller_pkg;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_COUNTER_WIDTH = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ITER  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/divider_controller_datapath.sv
// Purpose: shift/subtract divider datapath; one step per control pulse, result = floor(a/(2*b)).
// Latency: initialize takes 1 cycle, then DATA_WIDTH step pulses until done.
// Backpressure: none; it only moves when the controller pulses initialize/load_divident/sh_en.
module divider_datapath #(
    parameter int DATA_WIDTH    = 32,
    parameter int COUNTER_WIDTH = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  initialize,
    input  logic                  load_divident,
    input  logic                  sh_en,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  done,
    output logic                  divident_gt_divisor,
    output logic [DATA_WIDTH-1:0] result
);

    // Remainder, divisor aligned one position above the operand, quotient shift register, step count.
    logic [DATA_WIDTH-1:0]   rem;
    logic [2*DATA_WIDTH-1:0] div_shift;
    logic [DATA_WIDTH-1:0]   quo;
    logic [COUNTER_WIDTH-1:0] cnt;

    // The divisor starts at b*2^W and halves each step, so the last compare is at b*2; hence a/(2b).
    assign divident_gt_divisor = {{DATA_WIDTH{1'b0}}, rem} >= div_shift;
    assign done                = (cnt == COUNTER_WIDTH'(DATA_WIDTH));
    assign result              = quo;

    // Step registers: initialize loads operands, load_divident subtracts and shifts in 1, sh_en shifts in 0.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rem       <= '0;
            div_shift <= '0;
            quo       <= '0;
            cnt       <= '0;
        end else if (initialize) begin
            rem       <= dividend;
            div_shift <= {divisor, {DATA_WIDTH{1'b0}}};
            quo       <= '0;
            cnt       <= '0;
        end else if (load_divident) begin
            rem       <= rem - div_shift[DATA_WIDTH-1:0];
            div_shift <= div_shift >> 1;
            quo       <= {quo[DATA_WIDTH-2:0], 1'b1};
            cnt       <= cnt + 1'b1;
        end else if (sh_en) begin
            div_shift <= div_shift >> 1;
            quo       <= {quo[DATA_WIDTH-2:0], 1'b0};
            cnt       <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/divider_controller.sv
// Purpose: FSM sequencing one divider_datapath run per request, with abort/drain and divide-by-zero shortcut.
// Latency: div_valid rises DATA_WIDTH+3 cycles after an accepted start (1 cycle for a zero divisor).
// Backpressure: result held in RESP with div_valid until div_ack; div_start ignored while busy.
module divider_controller
    import divider_controller_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  div_start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic                  div_abort,
    input  logic                  div_ack,
    output logic                  div_busy,
    output logic                  div_valid,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic                  div_by_zero
);

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] op_a, op_b;
    logic                  initialize, load_divident, sh_en;
    logic                  done, divident_gt_divisor;
    logic [DATA_WIDTH-1:0] dp_result;

    divider_datapath #(
        .DATA_WIDTH   (DATA_WIDTH),
        .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_datapath (
        .CLK                (CLK),
        .RST                (RST),
        .initialize         (initialize),
        .load_divident      (load_divident),
        .sh_en              (sh_en),
        .dividend           (op_a),
        .divisor            (op_b),
        .done               (done),
        .divident_gt_divisor(divident_gt_divisor),
        .result             (dp_result)
    );

    assign div_busy  = (state != ST_IDLE);
    assign div_valid = (state == ST_RESP);

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath controls; at most one control is raised per cycle, never a step on done.
    always_comb begin
        state_nxt     = state;
        initialize    = 1'b0;
        load_divident = 1'b0;
        sh_en         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (div_start) begin
                    state_nxt = (divisor != '0) ? ST_INIT : ST_RESP;
                end
            end
            ST_INIT: begin
                initialize = 1'b1;
                state_nxt  = div_abort ? ST_DRAIN : ST_ITER;
            end
            ST_ITER: begin
                if (!done) begin
                    load_divident = divident_gt_divisor;
                    sh_en         = !divident_gt_divisor;
                end
                // Abort beats a simultaneous done so the result is discarded.
                if (div_abort) begin
                    state_nxt = ST_DRAIN;
                end else if (done) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_DRAIN: begin
                // Run the step counter out so the datapath ends in a known, finished state.
                if (!done) begin
                    sh_en = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (div_ack) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand latch on an accepted start with a non-zero divisor.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            op_a <= '0;
            op_b <= '0;
        end else if (state == ST_IDLE && div_start && divisor != '0) begin
            op_a <= dividend;
            op_b <= divisor;
        end
    end

    // Result registers: all-ones on zero divisor, datapath result on normal completion.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            quotient    <= '0;
            div_by_zero <= 1'b0;
        end else if (state == ST_IDLE && div_start && divisor == '0) begin
            quotient    <= '1;
            div_by_zero <= 1'b1;
        end else if (state == ST_ITER && done && !div_abort) begin
            quotient    <= dp_result;
            div_by_zero <= 1'b0;
        end
    end

endmodule

// File: doc/divider_controller.md
DIVIDER_CONTROLLER -- requirements
Module: divider_controller

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: operand and quotient width.
REQ-002 The block SHALL have parameter COUNTER_WIDTH, default 6: step-counter width passed to the datapath.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port div_start, input, 1 bit: request a division, sampled only in IDLE.
REQ-006 The block SHALL have port dividend, input, DATA_WIDTH bits: numerator, sampled with an accepted div_start.
REQ-007 The block SHALL have port divisor, input, DATA_WIDTH bits: denominator, sampled with an accepted div_start.
REQ-008 The block SHALL have port div_abort, input, 1 bit: cancel the division in progress.
REQ-009 The block SHALL have port div_ack, input, 1 bit: consumer accepts the result.
REQ-010 The block SHALL have port div_busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port div_valid, output, 1 bit: result held on quotient and div_by_zero.
REQ-012 The block SHALL have port quotient, output, DATA_WIDTH bits: registered result.
REQ-013 The block SHALL have port div_by_zero, output, 1 bit: the result came from a zero divisor.

Function
REQ-014 The FSM SHALL have states IDLE, INIT, ITER, DRAIN and RESP.
REQ-015 IDLE: div_start=1 with divisor!=0 SHALL latch both operands and go to INIT; with divisor==0 it SHALL go to RESP, set quotient to all-ones and set div_by_zero=1.
REQ-016 INIT SHALL assert datapath initialize for exactly 1 cycle with the latched operands, then go to ITER.
REQ-017 ITER with datapath done=0 SHALL assert exactly one step per cycle: load_divident if divident_gt_divisor=1, otherwise sh_en.
REQ-018 ITER with done=1 SHALL assert no step, capture datapath result into quotient, clear div_by_zero and go to RESP; a step on the done cycle is forbidden.
REQ-019 RESP SHALL hold div_valid=1 with stable quotient and div_by_zero until div_ack=1, then go to IDLE.
REQ-020 div_start outside IDLE SHALL be ignored, including when it arrives together with div_ack in RESP.
REQ-021 div_abort in INIT or ITER SHALL go to DRAIN.
REQ-022 DRAIN SHALL assert sh_en each cycle until done=1, then go to IDLE without asserting div_valid, so the datapath counter clears.
REQ-023 div_abort in IDLE, RESP or DRAIN SHALL be ignored; if div_abort and done=1 occur together in ITER, the abort wins and the state goes to DRAIN.
REQ-024 Latency: start accepted in cycle T gives initialize at T+1 and steps at T+2..T+DATA_WIDTH+1; div_valid SHALL rise at T+DATA_WIDTH+3 (35 for 32). For divide-by-zero, div_valid SHALL rise at T+1.
REQ-025 quotient SHALL be the datapath result unmodified; with the current 32-step schedule this equals floor(dividend/(2*divisor)).
REQ-026 initialize, load_divident and sh_en SHALL be mutually exclusive in every cycle.

Reset
REQ-027 RST=0 SHALL immediately force: state IDLE, div_busy=0, div_valid=0, quotient=0, div_by_zero=0, latched operands 0, all datapath controls 0.
REQ-028 The datapath SHALL share RST, so a reset in the middle of an operation also clears its counter; no drain is needed after reset.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (3 bits) and the default DATA_WIDTH/COUNTER_WIDTH constants.
REQ-030 The block SHALL instantiate exactly one sub-module, divider_datapath, with all of its ports internal except CLK and RST.
REQ-031 The FSM next-state and datapath-control logic SHALL be combinational from state, done and divident_gt_divisor; quotient and div_by_zero SHALL be registered.

Verification
REQ-032 Normal: start at T with 100/7 -> div_busy at T+1, initialize only at T+1, div_valid at T+35, quotient=7, div_by_zero=0.
REQ-033 Zero divisor: start with 55/0 -> div_valid at T+1, quotient=0xFFFFFFFF, div_by_zero=1, and initialize, load_divident and sh_en never asserted.
REQ-034 Backpressure: hold div_ack=0 for 10 cycles after div_valid -> quotient stays stable; div_ack=1 then gives IDLE next cycle; a div_start asserted in that same ack cycle is ignored.
REQ-035 Abort: 1000/3 with div_abort at step 10 -> DRAIN issues sh_en until done, no div_valid; then 1000/3 again gives quotient=166 at +35 cycles.
REQ-036 Reset: RST=0 at step 20 -> all outputs 0 asynchronously; after release, a new 100/7 gives quotient=7 at +35 cycles.
REQ-037 Protocol: a bench assertion SHALL check on every cycle that at most one datapath control is high and that no step is issued while done=1.
